// File: rtl/bpred_pkg.sv
// Shared constants, counter helpers and BTB entry type for the branch predictor.
package bpred_pkg;

    localparam int unsigned BPRED_INDEX_BITS = 6;
    localparam int unsigned BPRED_CTR_BITS   = 2;
    localparam int unsigned BPRED_TAG_BITS   = 8;
    localparam int unsigned BPRED_HIST_BITS  = 6;

    // Saturation ceiling of a bits-wide counter.
    function automatic int unsigned CTR_MAX(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    // Weakly not-taken reset value (01 for 2-bit, 0 for 1-bit).
    function automatic int unsigned CTR_WEAK_NT(input int unsigned bits);
        return (32'd1 << (bits - 32'd1)) - 32'd1;
    endfunction

    typedef struct packed {
        logic                      valid;
        logic [BPRED_TAG_BITS-1:0] tag;
        logic [31:0]               target;
    } btb_entry_t;

endpackage

// File: rtl/bpred_sat_ctr.sv
// Next-value logic for one saturating up/down branch counter.
module bpred_sat_ctr
    import bpred_pkg::*;
#(
    parameter int unsigned CTR_BITS = BPRED_CTR_BITS
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                inc_i,
    output logic [CTR_BITS-1:0] ctr_next_o
);

    localparam logic [CTR_BITS-1:0] MAX_VAL = CTR_BITS'(CTR_MAX(CTR_BITS));

    always_comb begin
        ctr_next_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != MAX_VAL) ctr_next_o = ctr_i + CTR_BITS'(1);
        end else begin
            if (ctr_i != '0) ctr_next_o = ctr_i - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// BHT of saturating counters plus tagged BTB; combinational lookup in F, trained in D.
// Optional gshare indexing (global history XOR PC index) when BPRED_GSHARE_EN is defined.
module branch_predictor_bht
    import bpred_pkg::*;
#(
    parameter int unsigned INDEX_BITS = BPRED_INDEX_BITS,
    parameter int unsigned CTR_BITS   = BPRED_CTR_BITS,
    parameter int unsigned TAG_BITS   = BPRED_TAG_BITS,
    parameter int unsigned HIST_BITS  = BPRED_HIST_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc_f,
    output logic                  pred_taken_f,
    output logic [31:0]           pred_target_f,
    output logic [INDEX_BITS-1:0] pred_cidx_f,
    input  logic                  update_en,
    input  logic [31:0]           update_pc_d,
    input  logic [INDEX_BITS-1:0] update_cidx_d,
    input  logic                  update_taken_d,
    input  logic [31:0]           update_target_d
);

    localparam int unsigned ENTRIES = 32'd1 << INDEX_BITS;
    localparam int unsigned TAG_LO  = INDEX_BITS + 2;
    localparam int unsigned TAG_HI  = INDEX_BITS + TAG_BITS + 1;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(CTR_WEAK_NT(CTR_BITS));

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] bidx_f, cidx_f, bidx_u;
    logic [TAG_BITS-1:0]   tag_f, tag_u;
    logic [CTR_BITS-1:0]   ctr_f, ctr_upd;
    logic                  hit_f;

    assign bidx_f = pc_f[INDEX_BITS+1:2];
    assign tag_f  = pc_f[TAG_HI:TAG_LO];
    assign bidx_u = update_pc_d[INDEX_BITS+1:2];
    assign tag_u  = update_pc_d[TAG_HI:TAG_LO];

`ifdef BPRED_GSHARE_EN
    logic [HIST_BITS-1:0] ghr_q, ghr_d;

    // History advances only on resolved branches (non-speculative).
    always_comb begin
        ghr_d = ghr_q;
        if (update_en) ghr_d = HIST_BITS'({ghr_q, update_taken_d});
    end

    always_ff @(posedge clk) begin
        if (reset) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end

    assign cidx_f = bidx_f ^ INDEX_BITS'(ghr_q);
`else
    localparam int unsigned UNUSED_HIST_BITS = HIST_BITS;
    assign cidx_f = bidx_f;
`endif

    // Lookup reads pre-update state; writes land on the next edge with no bypass.
    assign ctr_f         = ctr_q[cidx_f];
    assign hit_f         = valid_q[bidx_f] && (tag_q[bidx_f] == tag_f);
    assign pred_taken_f  = !reset && hit_f && ctr_f[CTR_BITS-1];
    assign pred_target_f = pred_taken_f ? target_q[bidx_f] : '0;
    assign pred_cidx_f   = cidx_f;

    bpred_sat_ctr #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_ctr (
        .ctr_i      (ctr_q[update_cidx_d]),
        .inc_i      (update_taken_d),
        .ctr_next_o (ctr_upd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RST;
            end
        end else if (update_en) begin
            ctr_q[update_cidx_d] <= ctr_upd;
            if (update_taken_d) begin
                valid_q[bidx_u]  <= 1'b1;
                tag_q[bidx_u]    <= tag_u;
                target_q[bidx_u] <= update_target_d;
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_f, update_pc_d};

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: driver queues expected lookups, monitor compares.
module tb_branch_predictor_bht;

    logic        clk;
    logic        reset;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic [5:0]  pred_cidx_f;
    logic        update_en;
    logic [31:0] update_pc_d;
    logic [5:0]  update_cidx_d;
    logic        update_taken_d;
    logic [31:0] update_target_d;

    branch_predictor_bht dut (
        .clk             (clk),
        .reset           (reset),
        .pc_f            (pc_f),
        .pred_taken_f    (pred_taken_f),
        .pred_target_f   (pred_target_f),
        .pred_cidx_f     (pred_cidx_f),
        .update_en       (update_en),
        .update_pc_d     (update_pc_d),
        .update_cidx_d   (update_cidx_d),
        .update_taken_d  (update_taken_d),
        .update_target_d (update_target_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [5:0]  cidx;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    logic chk_v;
    int   vec_id;
    int   vectors;
    int   miscompares;

    localparam logic [31:0] PC_A  = 32'h0040_0010;
    localparam logic [31:0] PC_B  = 32'h0040_0110;
    localparam logic [31:0] PC_C  = 32'h0040_0020;
    localparam logic [31:0] PC_HT = 32'h0040_8010;
    localparam logic [31:0] PC_HI = 32'h1040_0010;
    localparam logic [31:0] TGT_A = 32'h0040_0040;
    localparam logic [31:0] TGT_C = 32'h0040_0100;

    // One cycle: drive inputs after the edge, optionally queue an expected lookup.
    task automatic step(input logic rst, input logic [31:0] lpc, input logic chk,
                        input logic et, input logic [31:0] etg, input logic [5:0] ec,
                        input logic uen, input logic [31:0] upc, input logic [5:0] uc,
                        input logic ut, input logic [31:0] utg);
        exp_t e;
        reset           = rst;
        pc_f            = lpc;
        update_en       = uen;
        update_pc_d     = upc;
        update_cidx_d   = uc;
        update_taken_d  = ut;
        update_target_d = utg;
        chk_v           = chk;
        if (chk) begin
            e.taken  = et;
            e.target = etg;
            e.cidx   = ec;
            e.id     = vec_id;
            vec_id++;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever a lookup is presented, pop and compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_v) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_underflow: lookup presented with no expectation");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (pred_taken_f !== e.taken || pred_target_f !== e.target ||
                        pred_cidx_f !== e.cidx) begin
                        miscompares++;
                        $display("FAIL vec%0d: got taken=%b target=%h cidx=%0d, want taken=%b target=%h cidx=%0d",
                                 e.id, pred_taken_f, pred_target_f, pred_cidx_f,
                                 e.taken, e.target, e.cidx);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_id      = 0;
        vectors     = 0;
        miscompares = 0;
        chk_v       = 1'b0;
        reset       = 1'b1;
        pc_f        = '0;
        update_en   = 1'b0;
        update_pc_d = '0;
        update_cidx_d   = '0;
        update_taken_d  = 1'b0;
        update_target_d = '0;
        @(posedge clk);
        #1;

`ifdef BPRED_GSHARE_EN
        step(1, PC_A, 1, 0, 0, 6'd4, 0, 0,    6'd0, 0, 0);
        step(0, PC_A, 1, 0, 0, 6'd4, 1, PC_A, 6'd4, 1, TGT_A);
        step(0, PC_A, 1, 0, 0, 6'd5, 1, PC_A, 6'd5, 1, TGT_A);
        step(0, PC_A, 1, 0, 0, 6'd7, 0, 0,    6'd0, 0, 0);
        step(0, PC_C, 1, 0, 0, 6'd11, 0, 0,   6'd0, 0, 0);
        step(1, PC_A, 1, 0, 0, 6'd7, 0, 0,    6'd0, 0, 0);
        step(0, PC_A, 1, 0, 0, 6'd4, 0, 0,    6'd0, 0, 0);
`else
        // Reset and post-reset lookups.
        step(1, PC_A, 1, 0, 0, 6'd4, 0, 0, 6'd0, 0, 0);
        step(0, PC_A, 1, 0, 0, 6'd4, 0, 0, 6'd0, 0, 0);
        // Allocate with same-cycle lookup returning the old value.
        step(0, PC_A, 1, 0, 0, 6'd4, 1, PC_A, 6'd4, 1, TGT_A);
        step(0, PC_A,  1, 1, TGT_A, 6'd4, 0, 0, 6'd0, 0, 0);
        step(0, PC_HI, 1, 1, TGT_A, 6'd4, 0, 0, 6'd0, 0, 0);
        // Tag aliases at bidx 4.
        step(0, PC_B,  1, 0, 0, 6'd4, 0, 0, 6'd0, 0, 0);
        step(0, PC_HT, 1, 0, 0, 6'd4, 0, 0, 6'd0, 0, 0);
        // Saturate up, then hysteresis on two not-taken outcomes.
        for (int i = 0; i < 4; i++)
            step(0, PC_A, 1, 1, TGT_A, 6'd4, 1, PC_A, 6'd4, 1, TGT_A);
        step(0, PC_A, 1, 1, TGT_A, 6'd4, 1, PC_A, 6'd4, 0, 32'hDEAD_BEEF);
        step(0, PC_A, 1, 1, TGT_A, 6'd4, 1, PC_A, 6'd4, 0, 32'hDEAD_BEEF);
        step(0, PC_A, 1, 0, 0, 6'd4, 0, 0, 6'd0, 0, 0);
        // Counter-only training via another PC; A's BTB entry survives.
        step(0, PC_A, 1, 0, 0, 6'd4, 1, PC_C, 6'd4, 1, TGT_C);
        step(0, PC_A, 1, 1, TGT_A, 6'd4, 0, 0, 6'd0, 0, 0);
        step(0, PC_C, 1, 0, 0, 6'd8, 0, 0, 6'd0, 0, 0);
        // Reset wins over a concurrent update.
        step(1, PC_A, 1, 0, 0, 6'd4, 1, PC_A, 6'd4, 1, TGT_A);
        step(0, PC_A, 1, 0, 0, 6'd4, 0, 0, 6'd0, 0, 0);
        // Low saturation: 01 -> 00 -> 00 -> 01 -> 10.
        step(0, PC_A, 1, 0, 0, 6'd4, 1, PC_A, 6'd4, 0, 0);
        step(0, PC_A, 1, 0, 0, 6'd4, 1, PC_A, 6'd4, 0, 0);
        step(0, PC_A, 1, 0, 0, 6'd4, 1, PC_A, 6'd4, 1, TGT_A);
        step(0, PC_A, 1, 0, 0, 6'd4, 1, PC_A, 6'd4, 1, TGT_A);
        step(0, PC_A, 1, 1, TGT_A, 6'd4, 0, 0, 6'd0, 0, 0);
`endif

        chk_v = 1'b0;
        @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
